// File: rtl/jtkicker_sdram_pkg.sv
// Shared definitions for the BRAM-backed SDRAM responder.
//   st_e       : responder FSM state encoding
//   LAT_MIN/MAX: legal first-word latency range
//   burst_ok() : legal burst lengths (1, 2, 4)
package jtkicker_sdram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WAIT,
    ST_BURST,
    ST_REFRESH
  } st_e;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;

  function automatic bit burst_ok(input int b);
    return (b == 1) || (b == 2) || (b == 4);
  endfunction

endpackage

// File: rtl/jtkicker_sdram_bram.sv
// Single-port 2^AW x 16 RAM with byte write enables and a registered read.
//   clk, rst_n : clock; reset clears only the read register, never the array
//   addr       : word address shared by read and write
//   we[1:0]    : byte write enables, bit 1 covers [15:8]
//   wdata      : write data
//   re         : read enable; rdata only changes on a read
//   rdata      : registered read data
module jtkicker_sdram_bram #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic [1:0]    we,
  input  logic [15:0]   wdata,
  input  logic          re,
  output logic [15:0]   rdata
);

  logic [15:0] mem [2**AW];
  logic [15:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we[0]) mem[addr][7:0]  <= wdata[7:0];
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
  end

  // Holding the register between reads keeps the burst word stable on the bus.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/jtkicker_sdram_resp.sv
// Responder end of the game-side SDRAM slot bus, backed by block RAM.
//   downloading          : loader active, reads refused
//   prog_we/addr/data/mask: loader write (mask active low, bit 1 = [15:8])
//   sdram_req/addr       : read request level and first-word address
//   sdram_ack            : pulse on read acceptance / write completion
//   data_dst / data_rdy  : pulses on first / last burst word
//   data_read            : burst word, held between bursts
module jtkicker_sdram_resp
  import jtkicker_sdram_pkg::*;
#(
  parameter int AW         = 15,
  parameter int LAT        = 4,
  parameter int BURST      = 2,
  parameter int REF_PERIOD = 512,
  parameter int REF_LEN    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic        prog_we,
  input  logic [21:0] prog_addr,
  input  logic [15:0] prog_data,
  input  logic [1:0]  prog_mask,
  input  logic        sdram_req,
  input  logic [21:0] sdram_addr,
  output logic        sdram_ack,
  output logic        data_dst,
  output logic        data_rdy,
  output logic [15:0] data_read
);

  if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
    $error("jtkicker_sdram_resp: LAT out of range");
  end
  if (!burst_ok(BURST)) begin : g_bad_burst
    $error("jtkicker_sdram_resp: BURST must be 1, 2 or 4");
  end
  if (REF_LEN < 2) begin : g_bad_ref
    $error("jtkicker_sdram_resp: REF_LEN must be at least 2");
  end

  localparam int CW = 8;
  localparam int RW = $clog2(REF_PERIOD);
  localparam logic [CW-1:0] LAT_M1    = CW'(LAT - 1);
  localparam logic [CW-1:0] REF_M2    = CW'(REF_LEN - 2);
  localparam logic [2:0]    BURST_N   = 3'(BURST);
  localparam logic [2:0]    LAST_BEAT = 3'(BURST - 1);
  localparam logic [RW-1:0] REF_LAST  = RW'(REF_PERIOD - 1);

  st_e           st_d, st_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [2:0]    beat_d, beat_q;
  logic [AW-1:0] addr_d, addr_q;
  logic [15:0]   wdata_d, wdata_q;
  logic [1:0]    wmask_d, wmask_q;
  logic [RW-1:0] ref_cnt_d, ref_cnt_q;
  logic          pend_d, pend_q;
  logic          ack_d, ack_q, dst_d, dst_q, rdy_d, rdy_q;
  logic          ram_re;
  logic [1:0]    ram_we;
  logic          ref_hit;

  assign ref_hit = (ref_cnt_q == REF_LAST);

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    ref_cnt_d = ref_hit ? '0 : ref_cnt_q + RW'(1);
    pend_d    = pend_q | ref_hit;
    ack_d     = 1'b0;
    dst_d     = 1'b0;
    rdy_d     = 1'b0;
    ram_re    = 1'b0;
    ram_we    = 2'b00;
    unique case (st_q)
      ST_IDLE: begin
        beat_d = '0;
        if (pend_q) begin
          // The IDLE cycle that claims the refresh counts as its first cycle.
          st_d   = ST_REFRESH;
          cnt_d  = REF_M2;
          pend_d = ref_hit;
        end else if (prog_we) begin
          st_d    = ST_WRITE;
          ack_d   = 1'b1;
          addr_d  = prog_addr[AW-1:0];
          wdata_d = prog_data;
          wmask_d = prog_mask;
        end else if (sdram_req && !downloading) begin
          st_d   = ST_WAIT;
          ack_d  = 1'b1;
          addr_d = sdram_addr[AW-1:0];
          cnt_d  = LAT_M1;
        end
      end
      ST_WRITE: begin
        ram_we = ~wmask_q;
        st_d   = ST_IDLE;
      end
      ST_WAIT: begin
        // Word 0 is read here so it leaves the RAM register with data_dst.
        if (cnt_q == '0) begin
          ram_re = 1'b1;
          dst_d  = 1'b1;
          rdy_d  = (BURST == 1);
          beat_d = 3'd1;
          st_d   = ST_BURST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_BURST: begin
        // beat_q counts reads issued; the cycle after the last read shows the last word.
        if (beat_q < BURST_N) begin
          ram_re = 1'b1;
          rdy_d  = (beat_q == LAST_BEAT);
          beat_d = beat_q + 3'd1;
        end else begin
          st_d = ST_IDLE;
        end
      end
      ST_REFRESH: begin
        if (cnt_q == '0) st_d = ST_IDLE;
        else             cnt_d = cnt_q - CW'(1);
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      beat_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '1;
      ref_cnt_q <= '0;
      pend_q    <= 1'b0;
      ack_q     <= 1'b0;
      dst_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      ref_cnt_q <= ref_cnt_d;
      pend_q    <= pend_d;
      ack_q     <= ack_d;
      dst_q     <= dst_d;
      rdy_q     <= rdy_d;
    end
  end

  // beat is zero in WRITE and WAIT, so one adder serves both; it wraps in AW bits.
  jtkicker_sdram_bram #(.AW(AW)) u_bram (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr_q + AW'(beat_q)),
    .we    (ram_we),
    .wdata (wdata_q),
    .re    (ram_re),
    .rdata (data_read)
  );

  assign sdram_ack = ack_q;
  assign data_dst  = dst_q;
  assign data_rdy  = rdy_q;

endmodule

// File: doc/jtkicker_sdram_resp.md
# jtkicker_sdram_resp

Responder end of the game-side SDRAM slot bus: it accepts read requests from the ROM slot arbiter and download writes from the ROM loader, then returns burst data with the same `sdram_ack` / `data_dst` / `data_rdy` handshake the arbiter expects from the SDRAM controller. The store is a BRAM-backed ROM image with programmable latency and periodic refresh blackouts. It stands in for the SDRAM controller in simulation and in FPGA builds of small cores that fit in block RAM.

## Interface
- `AW`, 15: word-address width of the internal store (2^AW 16-bit words).
- `LAT`, 4: cycles from `sdram_ack` to the first data word; legal range 1..15.
- `BURST`, 2: 16-bit words per read; legal values 1, 2, 4.
- `REF_PERIOD`, 512: cycles between refresh requests.
- `REF_LEN`, 6: cycles spent in each refresh.

Ports:
- `clk`  in  1  system clock; the block's single clock.
- `rst_n`  in  1  asynchronous reset, active-low.
- `downloading`  in  1  loader active; reads are refused while high.
- `prog_we`  in  1  write request level, held until acknowledged.
- `prog_addr`  in  22  16-bit-word write address.
- `prog_data`  in  16  write data.
- `prog_mask`  in  2  byte mask, active low; bit 1 covers `[15:8]`.
- `sdram_req`  in  1  read request level.
- `sdram_addr`  in  22  16-bit-word read address of the first burst word.
- `sdram_ack`  out  1  one-cycle pulse marking acceptance of a read or completion of a write.
- `data_dst`  out  1  one-cycle pulse on the first burst word.
- `data_rdy`  out  1  one-cycle pulse on the last burst word.
- `data_read`  out  16  burst word; holds its last value between bursts.

## Operation
- FSM states: IDLE, WRITE, WAIT, BURST, REFRESH.
- **IDLE, priority order (highest first):**
  1. Refresh pending -> REFRESH.
  2. `prog_we` high -> WRITE.
  3. `sdram_req` high and `downloading` low -> WAIT. `sdram_addr` is latched and `sdram_ack` pulses on the next cycle.
- **WRITE:**
  - Writes the unmasked bytes of `prog_data` to `prog_addr[AW-1:0]`.
  - Pulses `sdram_ack` exactly one cycle after entry.
  - Returns to IDLE on the following cycle.
- **WAIT:**
  - Counts down `LAT-1` cycles after the ack cycle.
  - The memory read is issued one cycle before `data_dst` so that data is registered.
- **BURST:**
  - Outputs `BURST` consecutive words at latched address +0, +1, …; the increment wraps within `AW` bits.
  - `data_dst` pulses with word 0, `data_rdy` pulses with the last word. When `BURST`=1 both pulse in the same cycle.
  - Goes to IDLE after the last word.
- **REFRESH:**
  - Lasts `REF_LEN` cycles; no outputs toggle.
  - The refresh counter is free-running. When it reaches `REF_PERIOD-1` it sets a pending flag, which clears on entry to REFRESH.
  - A refresh falling due in WRITE, WAIT or BURST is deferred until IDLE; it never splits a transaction.
- **Address handling:** upper address bits above `AW` are ignored, so addresses alias.
- **`downloading` transitions:**
  - Rising during WAIT or BURST: the read completes normally.
  - Falling during WRITE: the write completes normally.
- **Held request:** if `sdram_req` is still high when IDLE is re-entered, it is treated as a new request, using the `sdram_addr` present at that cycle.

## Timing
- Reset values: `sdram_ack`, `data_dst`, `data_rdy` = 0; `data_read` = 16'h0000; FSM = IDLE; refresh counter = 0; pending flag = 0.
- Read: request sampled at cycle T; `sdram_ack` at T+1; `data_dst` at T+1+`LAT`; `data_rdy` at T+`LAT`+`BURST`; IDLE at T+`LAT`+`BURST`+1.
- Back-to-back reads: the next ack comes no earlier than 2 cycles after `data_rdy`.
- Write: `prog_we` sampled at T; `sdram_ack` at T+1. Data is readable by a read whose request is sampled at T+2 or later.
- Refresh: entry at cycle R; IDLE again at R+`REF_LEN`. Requests waiting during refresh are served from R+`REF_LEN`.
- Reset asserted mid-burst: all outputs clear asynchronously, no `data_rdy` is issued, and the memory contents are retained.

## Structure
- Shared package `jtkicker_sdram_pkg`:
  - FSM state encoding.
  - Legal-parameter check constants (`LAT` range, `BURST` set).
- Sub-module `jtkicker_sdram_bram`: single-port 2^AW x 16 RAM with a two-bit byte write enable and a registered read. The FSM, counters and refresh logic live in the top module.

## Test plan
- Reset, then write 16'hA55A at word 3 with mask 2'b00, then read at 3 with `LAT`=4, `BURST`=2:
  - ack at T+1, `data_dst` at T+5 with 16'hA55A, `data_rdy` at T+6 with word 4.
- Masked write of 16'h1234 with `prog_mask`=2'b01 over existing 16'hFFFF -> readback is 16'h12FF.
- Read at `sdram_addr`=2^AW-1 with `BURST`=2 -> the second word comes from address 0 (wrap).
- Request arriving on the exact cycle the refresh is due -> ack delayed by `REF_LEN` cycles. A refresh due mid-burst starts only after `data_rdy`.
- `sdram_req` high with `downloading` high -> no ack for 100 cycles. `downloading` falls -> ack within 1 cycle (plus any pending refresh).
- `rst_n` pulsed low at T+5 of a `LAT`=4 read:
  - outputs are 0 immediately and no `data_rdy` follows;
  - a later read returns the pre-reset memory contents.
